// File: rtl/seg_char_display.sv
// Display back-end: eight-entry scrolling character buffer, 7-segment font lookup,
// and active-low digit drive with anti-ghosting blanking and illegal-strobe flag.
module seg_char_display #(
    parameter int unsigned BLANK_CYCLES = 1
) (
    input  logic       clk_10Mhz,
    input  logic       reset,
    input  logic [7:0] an_sel,
    input  logic       char_valid,
    input  logic [5:0] char_code,
    output logic       char_ready,
    input  logic       clr,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       err
);

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned CODE_W = 6;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CODE_W-1:0] CODE_SPACE = CODE_W'(36);
    // The change cycle itself supplies the first dark sample, so the counter holds the remainder.
    localparam logic [CNT_W-1:0] BLANK_RELOAD =
        (BLANK_CYCLES == 0) ? '0 : CNT_W'(BLANK_CYCLES - 1);
    localparam bit BLANK_ON_CHANGE = (BLANK_CYCLES != 0);

    logic [CODE_W-1:0] entries [DEPTH];
    logic [7:0]        an_prev;
    logic [CNT_W-1:0]  blank_cnt;
    logic [CNT_W-1:0]  blank_cnt_d;
    logic              changed;
    logic              onehot;
    logic              dark;
    logic [CODE_W-1:0] sel_code;

    function automatic logic [6:0] font(input logic [CODE_W-1:0] code);
        logic [6:0] f;
        case (code)
            6'd0:  f = 7'h77;  6'd1:  f = 7'h7C;  6'd2:  f = 7'h39;  6'd3:  f = 7'h5E;
            6'd4:  f = 7'h79;  6'd5:  f = 7'h71;  6'd6:  f = 7'h3D;  6'd7:  f = 7'h76;
            6'd8:  f = 7'h30;  6'd9:  f = 7'h1E;  6'd10: f = 7'h75;  6'd11: f = 7'h38;
            6'd12: f = 7'h37;  6'd13: f = 7'h54;  6'd14: f = 7'h3F;  6'd15: f = 7'h73;
            6'd16: f = 7'h67;  6'd17: f = 7'h50;  6'd18: f = 7'h6D;  6'd19: f = 7'h78;
            6'd20: f = 7'h3E;  6'd21: f = 7'h1C;  6'd22: f = 7'h2A;  6'd23: f = 7'h36;
            6'd24: f = 7'h6E;  6'd25: f = 7'h5B;
            6'd26: f = 7'h3F;  6'd27: f = 7'h06;  6'd28: f = 7'h5B;  6'd29: f = 7'h4F;
            6'd30: f = 7'h66;  6'd31: f = 7'h6D;  6'd32: f = 7'h7D;  6'd33: f = 7'h07;
            6'd34: f = 7'h7F;  6'd35: f = 7'h6F;
            6'd63: f = 7'h40;
            default: f = 7'h00;
        endcase
        return f;
    endfunction

    assign char_ready = !clr;
    assign dp         = 1'b1;

    // Strobe decode, blanking decision and selected buffer entry.
    always_comb begin
        changed     = (an_sel != an_prev);
        onehot      = $onehot(an_sel);
        sel_code    = CODE_SPACE;
        blank_cnt_d = '0;
        dark        = 1'b0;
        if (changed) begin
            blank_cnt_d = BLANK_RELOAD;
            dark        = BLANK_ON_CHANGE;
        end else if (blank_cnt != '0) begin
            blank_cnt_d = blank_cnt - CNT_W'(1);
            dark        = 1'b1;
        end
        if (!onehot) begin
            dark = 1'b1;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (an_sel[i]) begin
                sel_code = entries[i];
            end
        end
    end

    always_ff @(posedge clk_10Mhz) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= CODE_SPACE;
            end
            an_prev   <= '0;
            blank_cnt <= '0;
            an        <= 8'hFF;
            seg       <= 7'h7F;
            err       <= 1'b0;
        end else begin
            if (clr) begin
                for (int i = 0; i < DEPTH; i++) begin
                    entries[i] <= CODE_SPACE;
                end
            end else if (char_valid) begin
                for (int i = DEPTH - 1; i > 0; i--) begin
                    entries[i] <= entries[i-1];
                end
                entries[0] <= char_code;
            end
            an_prev   <= an_sel;
            blank_cnt <= blank_cnt_d;
            if (dark) begin
                an  <= 8'hFF;
                seg <= 7'h7F;
            end else begin
                an  <= ~an_sel;
                seg <= ~font(sel_code);
            end
            err <= err | !onehot;
        end
    end

endmodule

// File: tb/tb_seg_char_display.sv
// Directed-vector bench for seg_char_display; stimulus queues expected outputs,
// a monitor pops one entry per cycle and compares against the selected instance.
module tb_seg_char_display;

    typedef struct {
        bit         chk;
        int         dut;
        logic [7:0] an;
        logic [6:0] seg;
        logic       err;
        logic       ready;
        int         tag;
    } exp_t;

    logic       clk_10Mhz = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] an_sel = 8'h00;
    logic       char_valid = 1'b0;
    logic [5:0] char_code = 6'd0;
    logic       clr = 1'b0;

    logic       ready1, dp1, err1, ready3, dp3, err3;
    logic [7:0] an1, an3;
    logic [6:0] seg1, seg3;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   tag   = 0;

    always #50 clk_10Mhz = ~clk_10Mhz;

    seg_char_display #(.BLANK_CYCLES(1)) u1 (
        .clk_10Mhz(clk_10Mhz), .reset(reset), .an_sel(an_sel), .char_valid(char_valid),
        .char_code(char_code), .char_ready(ready1), .clr(clr), .an(an1), .seg(seg1),
        .dp(dp1), .err(err1)
    );

    seg_char_display #(.BLANK_CYCLES(3)) u3 (
        .clk_10Mhz(clk_10Mhz), .reset(reset), .an_sel(an_sel), .char_valid(char_valid),
        .char_code(char_code), .char_ready(ready3), .clr(clr), .an(an3), .seg(seg3),
        .dp(dp3), .err(err3)
    );

    task automatic step(input logic r, input logic [7:0] s, input logic v, input logic [5:0] cd,
                        input logic c, input bit ck, input int d, input logic [7:0] ea,
                        input logic [6:0] es, input logic ee, input logic er);
        @(negedge clk_10Mhz);
        reset      = r;
        an_sel     = s;
        char_valid = v;
        char_code  = cd;
        clr        = c;
        exp_q.push_back('{ck, d, ea, es, ee, er, tag});
        tag++;
    endtask

    // Monitor: outputs are sampled shortly after each active edge.
    initial begin
        exp_t       e;
        logic [7:0] ga;
        logic [6:0] gs;
        logic       ge, gr, gd;
        forever begin
            @(posedge clk_10Mhz);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.chk) begin
                    if (e.dut == 3) begin
                        ga = an3; gs = seg3; ge = err3; gr = ready3; gd = dp3;
                    end else begin
                        ga = an1; gs = seg1; ge = err1; gr = ready1; gd = dp1;
                    end
                    n_vec++;
                    if (ga !== e.an || gs !== e.seg || ge !== e.err || gr !== e.ready || gd !== 1'b1) begin
                        n_bad++;
                        $display("FAIL vec%0d dut%0d: got an=%h seg=%h err=%b ready=%b dp=%b, want an=%h seg=%h err=%b ready=%b dp=1",
                                 e.tag, e.dut, ga, gs, ge, gr, gd, e.an, e.seg, e.err, e.ready);
                    end
                end
            end
        end
    end

    initial begin
        // Reset, then digit 0 with space
        step(1, 8'h00, 0, 0,  0, 1, 1, 8'hFF, 7'h7F, 0, 1);
        step(1, 8'h00, 0, 0,  0, 1, 3, 8'hFF, 7'h7F, 0, 1);
        step(0, 8'h01, 0, 0,  0, 1, 1, 8'hFF, 7'h7F, 0, 1);
        step(0, 8'h01, 0, 0,  0, 1, 1, 8'hFE, 7'h7F, 0, 1);
        step(0, 8'h01, 0, 0,  0, 1, 3, 8'hFF, 7'h7F, 0, 1);
        // Back-to-back A, B, C
        step(0, 8'h01, 1, 0,  0, 1, 3, 8'hFE, 7'h7F, 0, 1);
        step(0, 8'h01, 1, 1,  0, 1, 1, 8'hFE, 7'h08, 0, 1);
        step(0, 8'h01, 1, 2,  0, 1, 1, 8'hFE, 7'h03, 0, 1);
        step(0, 8'h01, 0, 0,  0, 1, 1, 8'hFE, 7'h46, 0, 1);
        step(0, 8'h02, 0, 0,  0, 1, 1, 8'hFF, 7'h7F, 0, 1);
        step(0, 8'h02, 0, 0,  0, 1, 1, 8'hFD, 7'h03, 0, 1);
        step(0, 8'h04, 0, 0,  0, 1, 1, 8'hFF, 7'h7F, 0, 1);
        step(0, 8'h04, 0, 0,  0, 1, 1, 8'hFB, 7'h08, 0, 1);
        // Nine pushes: digits '0'..'8'; '0' falls off the end
        for (int k = 0; k < 9; k++) begin
            step(0, 8'h04, 1, 6'(26 + k), 0, 0, 1, 8'hFF, 7'h7F, 0, 1);
        end
        step(0, 8'h80, 0, 0,  0, 1, 1, 8'hFF, 7'h7F, 0, 1);
        step(0, 8'h80, 0, 0,  0, 1, 1, 8'h7F, 7'h79, 0, 1);
        step(0, 8'h01, 0, 0,  0, 1, 1, 8'hFF, 7'h7F, 0, 1);
        step(0, 8'h01, 0, 0,  0, 1, 1, 8'hFE, 7'h00, 0, 1);
        // Decode error, reserved code, digit 9
        step(0, 8'h01, 1, 63, 0, 1, 1, 8'hFE, 7'h00, 0, 1);
        step(0, 8'h01, 1, 40, 0, 1, 1, 8'hFE, 7'h3F, 0, 1);
        step(0, 8'h01, 1, 35, 0, 1, 1, 8'hFE, 7'h7F, 0, 1);
        step(0, 8'h01, 0, 0,  0, 1, 1, 8'hFE, 7'h10, 0, 1);
        // clr beats char_valid
        step(0, 8'h01, 1, 26, 1, 1, 1, 8'hFE, 7'h10, 0, 0);
        step(0, 8'h01, 0, 0,  0, 1, 1, 8'hFE, 7'h7F, 0, 1);
        step(0, 8'h80, 0, 0,  0, 1, 1, 8'hFF, 7'h7F, 0, 1);
        step(0, 8'h80, 0, 0,  0, 1, 1, 8'h7F, 7'h7F, 0, 1);
        // Illegal strobes set the sticky flag
        step(0, 8'h03, 0, 0,  0, 1, 1, 8'hFF, 7'h7F, 1, 1);
        step(0, 8'h01, 0, 0,  0, 1, 1, 8'hFF, 7'h7F, 1, 1);
        step(0, 8'h01, 0, 0,  0, 1, 1, 8'hFE, 7'h7F, 1, 1);
        step(0, 8'h00, 0, 0,  0, 1, 3, 8'hFF, 7'h7F, 1, 1);
        // Three-cycle blanking, then a restart mid-blank
        step(0, 8'h01, 0, 0,  0, 1, 3, 8'hFF, 7'h7F, 1, 1);
        step(0, 8'h01, 0, 0,  0, 1, 3, 8'hFF, 7'h7F, 1, 1);
        step(0, 8'h01, 0, 0,  0, 1, 3, 8'hFF, 7'h7F, 1, 1);
        step(0, 8'h01, 0, 0,  0, 1, 3, 8'hFE, 7'h7F, 1, 1);
        step(0, 8'h02, 0, 0,  0, 1, 3, 8'hFF, 7'h7F, 1, 1);
        step(0, 8'h02, 0, 0,  0, 1, 3, 8'hFF, 7'h7F, 1, 1);
        step(0, 8'h02, 0, 0,  0, 1, 3, 8'hFF, 7'h7F, 1, 1);
        step(0, 8'h02, 0, 0,  0, 1, 3, 8'hFD, 7'h7F, 1, 1);
        step(0, 8'h01, 0, 0,  0, 1, 3, 8'hFF, 7'h7F, 1, 1);
        step(0, 8'h01, 0, 0,  0, 1, 3, 8'hFF, 7'h7F, 1, 1);
        step(0, 8'h02, 0, 0,  0, 1, 3, 8'hFF, 7'h7F, 1, 1);
        step(0, 8'h02, 0, 0,  0, 1, 3, 8'hFF, 7'h7F, 1, 1);
        step(0, 8'h02, 0, 0,  0, 1, 3, 8'hFF, 7'h7F, 1, 1);
        step(0, 8'h02, 0, 0,  0, 1, 3, 8'hFD, 7'h7F, 1, 1);
        // Reset mid-operation clears buffer, flag and blank state
        step(0, 8'h01, 1, 7,  0, 1, 1, 8'hFF, 7'h7F, 1, 1);
        step(0, 8'h01, 0, 0,  0, 1, 1, 8'hFE, 7'h09, 1, 1);
        step(1, 8'h02, 1, 8,  0, 1, 1, 8'hFF, 7'h7F, 0, 1);
        step(0, 8'h01, 0, 0,  0, 1, 1, 8'hFF, 7'h7F, 0, 1);
        step(0, 8'h01, 0, 0,  0, 1, 1, 8'hFE, 7'h7F, 0, 1);
        step(0, 8'h01, 0, 0,  0, 1, 3, 8'hFF, 7'h7F, 0, 1);
        step(0, 8'h01, 0, 0,  0, 1, 3, 8'hFE, 7'h7F, 0, 1);
        step(0, 8'h01, 0, 0,  0, 0, 1, 8'hFF, 7'h7F, 0, 1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk_10Mhz);
        end
        #2;
        if (exp_q.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/seg_char_display.md
# seg_char_display

Display back-end of the Morse decoder. Stores the last eight decoded characters in a scrolling buffer, accepts new characters over a valid/ready handshake, and converts the one-hot digit strobe from the anode ring counter into active-low anode and segment drive. Anti-ghosting blanking is applied on every digit change, and an illegal (non-one-hot) strobe is flagged. It sits between the character decoder and the board's 8-digit seven-segment display.

## Interface
- BLANK_CYCLES, 1, cycles all digits are dark after each an_sel change (0 to 15)
- clk_10Mhz  in  1  system clock
- reset  in  1  synchronous, active-high
- an_sel  in  8  one-hot digit strobe; bit i selects digit i (digit 0 rightmost)
- char_valid  in  1  char_code is offered this cycle
- char_code  in  6  0–25 = A–Z, 26–35 = 0–9, 36 = space, 63 = decode error, others = reserved
- char_ready  out  1  block can accept a character this cycle
- clr  in  1  clear the buffer to spaces
- an  out  8  anode drive, active-low
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low; constant 1
- err  out  1  sticky flag: non-one-hot an_sel seen

## Operation
- Buffer: 8 entries × 6 bits; entry 0 is the newest character.
- Accept: char_valid && char_ready at an edge. All entries shift up by one, entry 7 is discarded, and entry 0 takes char_code.
- char_ready = !clr. It is combinational and is the only path from an input to an output.
- clr: all entries become 36 (space) at the next edge.
  - clr and char_valid in the same cycle: clr wins and no character is accepted.
- Font (active-high gfedcba hex; seg is the bitwise inverse):
  - Letters: A 77, B 7C, C 39, D 5E, E 79, F 71, G 3D, H 76, I 30, J 1E, K 75, L 38, M 37, N 54, O 3F, P 73, Q 67, R 50, S 6D, T 78, U 3E, V 1C, W 2A, X 36, Y 6E, Z 5B.
  - Digits 0–9: 3F 06 5B 4F 66 6D 7D 07 7F 6F.
  - Space and reserved codes: 00. Code 63: 40 (dash).
- Digit select:
  - One-hot an_sel with bit i set: an = ~an_sel and seg = ~font(entry i), unless blanking is active.
- Blanking:
  - an_prev is a register holding the previously sampled an_sel.
  - Any cycle with an_sel != an_prev (re)loads the blank counter with BLANK_CYCLES.
  - While the counter is nonzero: an = 8'hFF, seg = 7'h7F. The counter decrements each cycle.
  - A change during blanking restarts the count.
- Invalid strobe: an_sel with zero or more than one bit set.
  - Outputs are blank for that sample.
  - err is set at the next edge and stays set until reset.
- Reset:
  - All entries = 36; an_prev = 0; blank counter = 0.
  - an = 8'hFF, seg = 7'h7F, dp = 1, err = 0.

## Timing
- an, seg and err are registered; dp is constant.
- Output latency is 1 cycle. Values at edge t+1 reflect an_sel, buffer and blank state sampled at edge t.
- Blanking for a change sampled at edge t:
  - Outputs are dark at t+1 through t+BLANK_CYCLES.
  - The first lit cycle is t+BLANK_CYCLES+1, provided an_sel is stable.
  - With BLANK_CYCLES = 0 there is no dark cycle.
- If an_sel changes every cycle and BLANK_CYCLES ≥ 1, the display stays dark. This is intended; the scan rate must be slowed upstream.
- First strobe after reset: an_prev = 0 differs from any one-hot value, so blanking applies to it.
- Write visibility: a character accepted at edge t is in entry 0 after t. It appears on seg at edge t+1 if digit 0 is selected and not blanked.
- Back-to-back accepts every cycle are supported. There are no stalls except clr.
- Reset mid-operation: all registers return to their reset values at that edge, regardless of other inputs.

## Test plan
- Reset, then hold an_sel = 8'h01 with BLANK_CYCLES = 1 → an = FF, seg = 7F for the first lit-check cycle; from the 3rd edge on, an = FE, seg = ~00 = 7F (space); err = 0.
- Push codes 0, 1, 2 (A, B, C) on consecutive cycles, then strobe digits 0 → 2 → entries show C, B, A.
  - Hold an_sel = 01: seg = 46 (~39).
  - Hold an_sel = 02: seg = 03 (~7C).
  - Hold an_sel = 04: seg = 08 (~77).
- Push 9 characters, then strobe digit 7 → it shows the 2nd character pushed; the 1st is discarded.
- Assert clr together with char_valid (code 26) → char_ready = 0 that cycle; all digits show space afterwards; code 26 is never displayed.
- an_sel = 8'h03 for one cycle → outputs dark for that sample; err = 1 from the next cycle and remains 1 after an_sel returns to one-hot; only reset clears it.
- BLANK_CYCLES = 3: change an_sel from 01 to 02 at edge t → an = FF at t+1..t+3 and an = FD at t+4. A second change at t+2 → dark until t+5.
